uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter between two byte-stream requesters: port 0 = CCD frame

---
 rtl/uart_tx_arbiter_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_if.sv | 21 ++
 rtl/uart_tx_arbiter_watchdog.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the two-port UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_NEXT    = 3'd2,
    ST_MARK    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Port 0 drains the CCD frame FIFO, port 1 carries status replies.
  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_STAT = 1'b1;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hFF;
  localparam int unsigned TIMEOUT_DEF   = 1_000_000;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_STAT) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the UART start/done handshake.
// slave = arbiter side, master = requesters and UART side.
interface uart_tx_arbiter_if;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       last0, last1;
  logic       ack0, ack1;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (
    output req0, req1, data0, data1, last0, last1, tx_done,
    input  ack0, ack1, tx_en, tx_data
  );

  modport slave (
    input  req0, req1, data0, data1, last0, last1, tx_done,
    output ack0, ack1, tx_en, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter_watchdog.sv
// Arbiter watchdog: counts while enabled, cleared on every state change,
// flags expiry combinationally on the last allowed cycle.
module uart_tx_arbiter_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int unsigned     TW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]   LIMIT = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] timer;

  // Restart on any state change, otherwise advance while a wait is in progress.
  always_ff @(posedge clk) begin
    if (rst || clear) timer <= '0;
    else if (en)      timer <= timer + 1'b1;
  end

  assign expire = en && (timer == LIMIT);
endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-port, packet-atomic, round-robin arbiter in front of one UART transmitter.
// Optional feature macro: FRAME_MARKER_EN appends SYNC_BYTE after each port-0 packet.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err_timeout
);
  state_t     state, state_nxt;
  logic       owner, rr_ptr, last_q, tx_en_q, err_q;
  logic [7:0] tx_data_q;
  logic [1:0] ack_q, req;
  logic       pick, take, abort, use_mark, expire, wd_en;
  logic [7:0] pick_data;
  logic       pick_last;

  assign req       = {bus.req1, bus.req0};
  assign pick_data = pick ? bus.data1 : bus.data0;
  assign pick_last = pick ? bus.last1 : bus.last0;
  assign wd_en     = (state == ST_SEND) || (state == ST_NEXT) || (state == ST_MARK);

`ifdef FRAME_MARKER_EN
  assign use_mark = (owner == PORT_DATA);
`else
  assign use_mark = 1'b0;
`endif

  uart_tx_arbiter_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_nxt != state),
    .en     (wd_en),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state; tx_done beats the watchdog, and the NEXT state ignores the
  // owner's req during the ack cycle because it still carries the old byte.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    abort     = 1'b0;
    pick      = owner;
    unique case (state)
      ST_IDLE: if (|req) begin
        pick      = (&req) ? rr_ptr : req[1];
        take      = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (bus.tx_done)
          state_nxt = !last_q ? ST_NEXT : (use_mark ? ST_MARK : ST_RELEASE);
        else if (expire) begin
          abort     = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_NEXT: begin
        if (req[owner] && (ack_q == 2'b00)) begin
          take      = 1'b1;
          state_nxt = ST_SEND;
        end else if (expire) begin
          abort     = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
`ifdef FRAME_MARKER_EN
      ST_MARK: begin
        if (bus.tx_done && tx_en_q) state_nxt = ST_RELEASE;
        else if (expire) begin
          abort     = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
`endif
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; grant stays up through RELEASE.
  always_comb begin
    grant = (state == ST_IDLE) ? 2'b00 : port_onehot(owner);
    busy  = (state != ST_IDLE);
  end

  // Datapath: byte latch, UART start level, ack/err pulses, round-robin pointer.
  // In MARK tx_en re-rises one cycle after the data byte's done so the UART sees a fresh start.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= PORT_DATA;
      rr_ptr    <= PORT_DATA;
      last_q    <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      ack_q     <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 2'b00;
      err_q <= abort;
      if (take) begin
        owner     <= pick;
        tx_data_q <= pick_data;
        last_q    <= pick_last;
        tx_en_q   <= 1'b1;
      end else if (state == ST_SEND && bus.tx_done) begin
        tx_en_q <= 1'b0;
        ack_q   <= port_onehot(owner);
        if (state_nxt == ST_MARK) tx_data_q <= SYNC_BYTE;
      end else if (state == ST_MARK) begin
        if (!tx_en_q)         tx_en_q <= 1'b1;
        else if (bus.tx_done) tx_en_q <= 1'b0;
      end
      if (abort) tx_en_q <= 1'b0;
      if (state == ST_RELEASE) rr_ptr <= ~owner;
    end
  end

  assign bus.tx_en   = tx_en_q;
  assign bus.tx_data = tx_data_q;
  assign bus.ack0    = ack_q[0];
  assign bus.ack1    = ack_q[1];
  assign err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a UART that answers 10 cycles
// after each tx_en rise, and a per-port byte-stream scoreboard.
module tb_uart_tx_arbiter;
  localparam int         TO   = 50;
  localparam logic [7:0] SYNC = 8'hFF;
`ifdef FRAME_MARKER_EN
  localparam bit MARK_ON = 1'b1;
`else
  localparam bit MARK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       busy, err_timeout;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.TIMEOUT_CYC(TO), .SYNC_BYTE(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .grant       (grant),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] q0[$], q1[$];
  logic [8:0] exp0[$], exp1[$];
  logic [9:0] obs[$];
  int  exp_ack0 = 0, exp_ack1 = 0;
  int  ack0_cnt = 0, ack1_cnt = 0, both_cnt = 0;
  bit  uart_mute = 1'b0;
  int  ucnt = 0;
  bit  prev_en = 1'b0;
  int  rr;

  // Requesters: present queue front, pop it on ack.
  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.data0 = 0; bus.data1 = 0; bus.last0 = 0; bus.last1 = 0;
    forever begin
      @(negedge clk);
      if (!rst && bus.ack0 && q0.size() > 0) void'(q0.pop_front());
      if (!rst && bus.ack1 && q1.size() > 0) void'(q1.pop_front());
      bus.req0  = (q0.size() > 0);
      bus.data0 = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      bus.last0 = (q0.size() > 0) ? q0[0][8]   : 1'b0;
      bus.req1  = (q1.size() > 0);
      bus.data1 = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      bus.last1 = (q1.size() > 0) ? q1[0][8]   : 1'b0;
    end
  end

  // UART: done pulse 10 cycles after tx_en rises, unless muted.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_mute || !bus.tx_en) begin
        bus.tx_done = 1'b0;
        ucnt = 0;
      end else begin
        ucnt++;
        bus.tx_done = (ucnt == 10);
      end
    end
  end

  // Monitor: every started byte with its owner, and ack pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_en && !prev_en) obs.push_back({grant, bus.tx_data});
      prev_en = bus.tx_en;
      if (bus.ack0) ack0_cnt++;
      if (bus.ack1) ack1_cnt++;
      if (bus.ack0 && bus.ack1) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [1:0] onehot(input int p);
    return (p != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push_pkt(input int p, input int len, input logic [7:0] base, input bit rnd);
    logic [7:0] d;
    logic       lst;
    for (int i = 0; i < len; i++) begin
      d   = rnd ? 8'($urandom) : base + 8'(i);
      lst = (i == len - 1);
      if (p == 0) begin
        q0.push_back({lst, d});
        exp0.push_back({lst && !MARK_ON, d});
      end else begin
        q1.push_back({lst, d});
        exp1.push_back({lst, d});
      end
    end
    if (p == 0) begin
      exp_ack0 += len;
      if (MARK_ON) exp0.push_back({1'b1, SYNC});
    end else begin
      exp_ack1 += len;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (q0.size() == 0 && q1.size() == 0 && !busy && !bus.tx_en) begin ok = 1'b1; break; end
    end
    chk({tag, "_idle"}, 32'(ok), 1);
  endtask

  task automatic wait_txen(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (bus.tx_en) begin ok = 1'b1; break; end
    end
    chk({tag, "_txen"}, 32'(ok), 1);
  endtask

  // Cycles from now until err_timeout is seen (bounded).
  task automatic cycles_to_err(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      n++;
      if (err_timeout) break;
    end
  endtask

  // Each port's bytes must appear in order, a port may only lose the UART
  // after its packet end, and acks must match the bytes actually delivered.
  task automatic score(input string tag);
    int         i0 = 0, i1 = 0, prevp = -1, p;
    logic       pend = 1'b1;
    logic [1:0] g;
    logic [7:0] d;
    foreach (obs[k]) begin
      g = obs[k][9:8];
      d = obs[k][7:0];
      chk({tag, "_grant"}, 32'(g == 2'b01 || g == 2'b10), 1);
      p = (g == 2'b10) ? 1 : 0;
      if (prevp >= 0 && p != prevp) chk({tag, "_atomic"}, 32'(pend), 1);
      if (p == 0) begin
        chk({tag, "_extra0"}, 32'(i0 < exp0.size()), 1);
        if (i0 < exp0.size()) begin
          chk($sformatf("%s_p0_byte%0d", tag, i0), 32'(d), 32'(exp0[i0][7:0]));
          pend = exp0[i0][8];
          i0++;
        end
      end else begin
        chk({tag, "_extra1"}, 32'(i1 < exp1.size()), 1);
        if (i1 < exp1.size()) begin
          chk($sformatf("%s_p1_byte%0d", tag, i1), 32'(d), 32'(exp1[i1][7:0]));
          pend = exp1[i1][8];
          i1++;
        end
      end
      prevp = p;
    end
    chk({tag, "_count0"}, 32'(i0), 32'(exp0.size()));
    chk({tag, "_count1"}, 32'(i1), 32'(exp1.size()));
    chk({tag, "_ack0"}, 32'(ack0_cnt), 32'(exp_ack0));
    chk({tag, "_ack1"}, 32'(ack1_cnt), 32'(exp_ack1));
    obs.delete(); exp0.delete(); exp1.delete();
  endtask

  initial begin
    int n, p;
    // Reset values.
    step(3);
    chk("rst_tx_en",   32'(bus.tx_en), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_grant",   32'(grant), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_err",     32'(err_timeout), 0);
    chk("rst_acks",    32'({bus.ack1, bus.ack0}), 0);
    rst = 1'b0;
    rr  = 0;

    // Simultaneous requests: pointer port first, then the other.
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 2, 8'h10, 1'b0);
      push_pkt(1, 1, 8'h20, 1'b0);
      wait_idle("tie");
      chk($sformatf("tie%0d_first", r), 32'(obs[0][9:8]), 32'(onehot(rr)));
      chk($sformatf("tie%0d_second", r), 32'(obs[obs.size()-1][9:8]), 32'(onehot(1 - rr)));
      score("tie");
      rr = 1 - (1 - rr);
    end

    // Port 1 arrives mid port-0 packet and must wait for its end.
    push_pkt(0, 3, 8'hA1, 1'b0);
    wait_txen("mid");
    push_pkt(1, 2, 8'hB1, 1'b0);
    wait_idle("mid");
    chk("mid_size", 32'(obs.size()), 32'(5 + int'(MARK_ON)));
    chk("mid_first", 32'(obs[0][9:8]), 2'b01);
    chk("mid_last", 32'(obs[obs.size()-1][9:8]), 2'b10);
    score("mid");

    // Owner stalls in NEXT: abort TO cycles after ack.
    q0.push_back({1'b0, 8'h5A});
    exp0.push_back({1'b1, 8'h5A});
    exp_ack0++;
    n = 0;
    for (int i = 0; i < 200; i++) begin step(1); if (bus.ack0) break; n++; end
    chk("next_ack_seen", 32'(n < 200), 1);
    cycles_to_err(n);
    chk("next_timeout_cycles", 32'(n), TO);
    step(1);
    chk("next_err_width", 32'(err_timeout), 0);
    chk("next_grant", 32'(grant), 0);
    chk("next_busy", 32'(busy), 0);
    score("next_to");

    // UART never answers: abort TO cycles after start, no ack.
    uart_mute = 1'b1;
    q1.push_back({1'b1, 8'hC3});
    exp1.push_back({1'b1, 8'hC3});
    wait_txen("mute");
    cycles_to_err(n);
    chk("mute_timeout_cycles", 32'(n), TO);
    chk("mute_tx_en", 32'(bus.tx_en), 0);
    q1.delete();
    uart_mute = 1'b0;
    wait_idle("mute");
    score("mute");

    // Reset mid packet, then a clean restart.
    q0.push_back({1'b0, 8'hD1});
    q0.push_back({1'b1, 8'hD2});
    exp0.push_back({1'b1, 8'hD1});
    wait_txen("rst");
    step(3);
    rst = 1'b1;
    q0.delete();
    step(1);
    chk("rst_mid_tx_en", 32'(bus.tx_en), 0);
    chk("rst_mid_grant", 32'(grant), 0);
    chk("rst_mid_busy",  32'(busy), 0);
    rst = 1'b0;
    push_pkt(1, 2, 8'hE1, 1'b0);
    wait_idle("restart");
    score("restart");

    // Randomized packets with random overlap.
    for (int r = 0; r < 10; r++) begin
      p = $urandom_range(0, 1);
      push_pkt(p, $urandom_range(1, 4), 8'h00, 1'b1);
      step($urandom_range(0, 40));
      push_pkt($urandom_range(0, 1), $urandom_range(1, 4), 8'h00, 1'b1);
      wait_idle($sformatf("rnd%0d", r));
      score($sformatf("rnd%0d", r));
    end

    chk("ack_exclusive", 32'(both_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
